div_rem_dispatch: RTL and testbench

//  Front-end stage for RV32M DIV/DIVU/REM/REMU, directly upstream of the unsigned handshake divider core.

---
 rtl/div_rem_dispatch.sv | 198 +++++++++++++++++++
 tb/tb_div_rem_dispatch.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rem_dispatch.sv
// -----------------------------------------------------------------------------
// div_rem_dispatch
//
// Front-end stage for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU).
// It sits directly upstream of an unsigned valid/ready divider core.
//  - Divide-by-zero and signed overflow are resolved locally, with no core
//    transaction.
//  - Every other op sends unsigned magnitudes to the core, then sign-corrects
//    the returned quotient or remainder.
//
// Ports
//  clock, reset        rising-edge clock, asynchronous active-high reset
//  in_valid_i/ready_o  request handshake from issue; op_i, rs1_i, rs2_i operands
//  flush_i             kill the in-flight op (no result is produced for it)
//  out_valid_o/ready_i result handshake; result_o is the final rd value
//  div_valid_o/ready_i request handshake to the core; div_a_o/div_b_o magnitudes
//  div_valid_i/ready_o result handshake from the core; div_q_i/div_r_i results
//
// Every output is a decode of the state register or a register itself.
// There is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module div_rem_dispatch #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            div_valid_o,
    input  logic            div_ready_i,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    input  logic            div_valid_i,
    output logic            div_ready_o,
    input  logic [XLEN-1:0] div_q_i,
    input  logic [XLEN-1:0] div_r_i
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic            rem_q;     // latched op is REM/REMU
    logic            neg_q;     // final result must be negated
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] result_q;

    // ---------------------------------------------------------------- decode
    logic            is_signed;
    logic            sign_a;
    logic            sign_b;
    logic            div_by_zero;
    logic            overflow;
    logic            special;
    logic            accept;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] special_val;
    logic [XLEN-1:0] core_val;
    logic [XLEN-1:0] core_res;

    assign is_signed   = ~op_i[0];
    assign sign_a      = is_signed & rs1_i[XLEN-1];
    assign sign_b      = is_signed & rs2_i[XLEN-1];
    // The magnitude of the most negative value wraps back onto itself.
    // That is the correct unsigned magnitude (2^(XLEN-1)).
    assign mag_a       = sign_a ? ('0 - rs1_i) : rs1_i;
    assign mag_b       = sign_b ? ('0 - rs2_i) : rs2_i;
    assign div_by_zero = (rs2_i == '0);
    assign overflow    = is_signed & (rs1_i == MIN_NEG) & (rs2_i == ALL_ONES);
    assign special     = div_by_zero | overflow;

    always_comb begin
        special_val = '0;
        if (div_by_zero) begin
            special_val = op_i[1] ? rs1_i : ALL_ONES;
        end else begin
            special_val = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // A flush in IDLE blocks acceptance even though in_ready_o is high.
    assign accept   = (state_q == S_IDLE) & in_valid_i & ~flush_i;

    assign core_val = rem_q ? div_r_i : div_q_i;
    assign core_res = neg_q ? ('0 - core_val) : core_val;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A handshake in the flush cycle still leaves a result
                // in the core, so that result must be drained.
                if (flush_i) begin
                    state_d = div_ready_i ? S_DRAIN : S_IDLE;
                end else if (div_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // div_ready_o is high in WAIT. A result arriving in the flush
                // cycle is therefore already swallowed, and there is nothing
                // left to drain.
                if (flush_i) begin
                    state_d = div_valid_i ? S_IDLE : S_DRAIN;
                end else if (div_valid_i) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (flush_i || out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (div_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                rem_q <= op_i[1];
                neg_q <= op_i[1] ? sign_a : (sign_a ^ sign_b);
                if (special) begin
                    result_q <= special_val;
                end else begin
                    a_q <= mag_a;
                    b_q <= mag_b;
                end
            end
            // Clear the operands once the request leaves ISSUE. This keeps
            // div_a_o/div_b_o at zero whenever div_valid_o is low.
            if (state_q == S_ISSUE && (flush_i || div_ready_i)) begin
                a_q <= '0;
                b_q <= '0;
            end
            if (state_q == S_WAIT && div_valid_i && !flush_i) begin
                result_q <= core_res;
            end
            if (state_q == S_RESP && (flush_i || out_ready_i)) begin
                result_q <= '0;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_RESP);
    assign result_o    = result_q;
    assign div_valid_o = (state_q == S_ISSUE);
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign div_ready_o = (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_div_rem_dispatch.sv
// -----------------------------------------------------------------------------
// tb_div_rem_dispatch
//
// Self-checking bench for div_rem_dispatch.
//  - An unsigned divider core is emulated here, with random ready stalls and
//    random result latency.
//  - Results are compared against a reference model that uses plain signed
//    and unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_div_rem_dispatch;

    localparam int XLEN = 32;

    logic            clock;
    logic            reset;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] result_o;
    logic            div_valid_o;
    logic            div_ready_i;
    logic [XLEN-1:0] div_a_o;
    logic [XLEN-1:0] div_b_o;
    logic            div_valid_i;
    logic            div_ready_o;
    logic [XLEN-1:0] div_q_i;
    logic [XLEN-1:0] div_r_i;

    div_rem_dispatch #(.XLEN(XLEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_i        (op_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .div_valid_o (div_valid_o),
        .div_ready_i (div_ready_i),
        .div_a_o     (div_a_o),
        .div_b_o     (div_b_o),
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .div_q_i     (div_q_i),
        .div_r_i     (div_r_i)
    );

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    int vectors     = 0;
    int miscompares = 0;

    // Core emulation state, shared with the main sequence.
    int          core_req_cnt = 0;
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    bit          core_busy = 0;
    bit          core_stall = 0;
    int          core_dly_max = 0;
    int          core_dly_fix = -1;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ------------------------------------------------------------ reference
    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_mag(input logic [1:0] op, input logic [31:0] x);
        logic signed [31:0] s;
        s = x;
        if (!op[0] && s < 0) return 32'(-s);
        return x;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            OP_DIVU: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // ------------------------------------------------------------ core model
    initial begin
        bit          hs_pend;
        bit          rsp_pend;
        bit          rsp_v;
        bit          sv_prev;
        logic [31:0] hs_a;
        logic [31:0] hs_b;
        logic [31:0] sv_a;
        logic [31:0] sv_b;
        int          dly;
        hs_pend = 0; rsp_pend = 0; rsp_v = 0; sv_prev = 0; dly = 0;
        hs_a = '0; hs_b = '0; sv_a = '0; sv_b = '0;
        div_ready_i = 1'b0;
        div_valid_i = 1'b0;
        div_q_i     = '0;
        div_r_i     = '0;
        forever begin
            tick();
            if (reset) begin
                hs_pend = 0; rsp_pend = 0; rsp_v = 0; sv_prev = 0;
                core_busy   = 0;
                div_ready_i = 1'b0;
                div_valid_i = 1'b0;
                continue;
            end
            if (hs_pend) begin
                core_req_cnt++;
                last_a    = hs_a;
                last_b    = hs_b;
                core_busy = 1;
                dly = (core_dly_fix >= 0) ? core_dly_fix : int'($urandom_range(core_dly_max, 0));
            end
            if (rsp_pend) begin
                core_busy = 0;
                rsp_v     = 0;
            end
            if (sv_prev && div_valid_o) begin
                check_eq("div_a_stable", div_a_o, sv_a);
                check_eq("div_b_stable", div_b_o, sv_b);
            end
            if (div_valid_o) check_eq("div_b_nonzero", 32'(div_b_o == '0), 32'd0);
            if (core_busy && !rsp_v) begin
                if (dly == 0) begin
                    rsp_v   = 1;
                    div_q_i = last_a / last_b;
                    div_r_i = last_a % last_b;
                end else begin
                    dly--;
                end
            end
            div_valid_i = rsp_v;
            div_ready_i = div_valid_o && !core_busy && (core_stall ? ($urandom_range(1, 0) == 1) : 1'b1);
            hs_pend  = div_valid_o && div_ready_i;
            hs_a     = div_a_o;
            hs_b     = div_b_o;
            rsp_pend = div_valid_i && div_ready_o;
            sv_prev  = div_valid_o && !div_ready_i;
            sv_a     = div_a_o;
            sv_b     = div_b_o;
        end
    end

    // ------------------------------------------------------------ transactions
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
        int          n;
        int          req0;
        bit          spec;
        logic [31:0] exp;
        logic [31:0] held;
        spec = is_special(op, a, b);
        exp  = ref_result(op, a, b);
        n = 0;
        while (!in_ready_o && n < 100) begin tick(); n++; end
        check_eq("in_ready_idle", 32'(in_ready_o), 32'd1);
        req0 = core_req_cnt;
        op_i = op; rs1_i = a; rs2_i = b; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check_eq("in_ready_drop", 32'(in_ready_o), 32'd0);
        if (spec) check_eq("special_latency", 32'(out_valid_o), 32'd1);
        n = 0;
        while (!out_valid_o && n < 500) begin tick(); n++; end
        check_eq("out_valid", 32'(out_valid_o), 32'd1);
        check_eq("result", result_o, exp);
        check_eq("core_requests", 32'(core_req_cnt - req0), spec ? 32'd0 : 32'd1);
        if (!spec) begin
            check_eq("core_a", last_a, ref_mag(op, a));
            check_eq("core_b", last_b, ref_mag(op, b));
        end
        held = result_o;
        for (int k = 0; k < stall; k++) begin
            tick();
            check_eq("bp_result", result_o, held);
            check_eq("bp_in_ready", 32'(in_ready_o), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid_o), 32'd1);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check_eq("in_ready_after", 32'(in_ready_o), 32'd1);
        check_eq("out_valid_after", 32'(out_valid_o), 32'd0);
        $display("op=%0d rs1=0x%08h rs2=0x%08h result=0x%08h expected=0x%08h special=%0d",
                 op, a, b, held, exp, spec);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  32'(in_ready_o),  32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check_eq({tag, "_result"},    result_o,         32'd0);
        check_eq({tag, "_div_valid"}, 32'(div_valid_o), 32'd0);
        check_eq({tag, "_div_ready"}, 32'(div_ready_o), 32'd0);
        check_eq({tag, "_div_a"},     div_a_o,          32'd0);
        check_eq({tag, "_div_b"},     div_b_o,          32'd0);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        int          n;
        bit          saw;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1;
        in_valid_i = 1'b0; op_i = 2'b00; rs1_i = '0; rs2_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Directed cases
        do_op(OP_DIVU, 32'd59699056, 32'd87783792, 0);
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 0);
        do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 0);
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(OP_DIVU, 32'd5, 32'd0, 0);
        do_op(OP_REMU, 32'd5, 32'd0, 0);
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 10);

        // A flush in IDLE blocks acceptance.
        op_i = OP_DIVU; rs1_i = 32'd5; rs2_i = 32'd0; in_valid_i = 1'b1; flush_i = 1'b1;
        tick();
        in_valid_i = 1'b0; flush_i = 1'b0;
        check_eq("idle_flush_in_ready", 32'(in_ready_o), 32'd1);
        check_eq("idle_flush_out_valid", 32'(out_valid_o), 32'd0);

        // A flush in RESP drops the result.
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check_eq("resp_reached", 32'(out_valid_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("resp_flush_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("resp_flush_in_ready", 32'(in_ready_o), 32'd1);

        // Random ops with core stalls
        core_stall = 1;
        core_dly_max = 4;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7, 0))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 0) ? 32'($urandom_range(20, 1)) : 32'(-$urandom_range(20, 1));
                3: ra = 32'($urandom_range(100, 0));
                default: ;
            endcase
            do_op(rop, ra, rb, int'($urandom_range(2, 0)));
        end
        core_stall = 0;

        // A flush in WAIT drains the late core result.
        core_dly_fix = 15;
        op_i = OP_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (!div_ready_o && n < 50) begin tick(); n++; end
        check_eq("flush_reach_wait", 32'(div_ready_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check_eq("drain_in_ready", 32'(in_ready_o), 32'd0);
        check_eq("drain_div_ready", 32'(div_ready_o), 32'd1);
        saw = 0;
        n = 0;
        while (!in_ready_o && n < 100) begin
            if (out_valid_o) saw = 1;
            tick();
            n++;
        end
        check_eq("drain_no_out_valid", 32'(saw), 32'd0);
        check_eq("drain_done", 32'(in_ready_o), 32'd1);
        tick();
        check_eq("drain_core_idle", 32'(core_busy), 32'd0);
        core_dly_fix = -1;
        do_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);

        // An asynchronous reset in the middle of WAIT
        core_dly_fix = 20;
        op_i = OP_DIV; rs1_i = 32'd50; rs2_i = 32'd5; in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        n = 0;
        while (!div_ready_o && n < 50) begin tick(); n++; end
        check_eq("rst_reach_wait", 32'(div_ready_o), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick(); tick();
        reset = 1'b0;
        core_dly_fix = -1;
        tick();
        do_op(OP_DIVU, 32'd10, 32'd3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
